data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//   Memory-phase access unit between the single-cycle datapath and a wait-stated data bus.
//   Takes the ALU address and the store data (busB) and issues one bus transaction per request.
//   Builds byte enables and store lanes for sb/sh/sw, and aligns and extends lb/lbu/lh/lhu/lw.
//   Stalls the PC until the access completes.
// PARAMETERS
//   TIMEOUT_CYC  255  max cycles in ACCESS waiting for i_bus_ack before bus error (>=1)
// PORTS
//   i_clk        in   1   clock
//   i_rst_n      in   1   asynchronous active-low reset
//   i_req        in   1   load/store request; held stable by datapath until o_done
//   i_we         in   1   1=store, 0=load
//   i_size       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   i_signed     in   1   1=sign-extend load (lb/lh), 0=zero-extend (lbu/lhu)
//   i_addr       in   32  byte address (ALU result)
//   i_wdata      in   32  store data (busB)
//   o_rdata      out  32  aligned/extended load data
//   o_stall      out  1   freeze PC and regfile write while access pending
//   o_done       out  1   one-cycle completion pulse
//   o_bus_err    out  1   one-cycle pulse with o_done on timeout
//   o_misalign   out  1   one-cycle pulse with o_done on misaligned access (coproc0 cause)
//   o_bus_req    out  1   bus request, held until ack/timeout
//   o_bus_we     out  1   bus write
//   o_bus_addr   out  30  word address = i_addr[31:2]
//   o_bus_be     out  4   byte enables, bit n = byte lane n
//   o_bus_wdata  out  32  lane-replicated store data
//   i_bus_ack    in   1   bus completes in this cycle
//   i_bus_rdata  in   32  read word, valid with i_bus_ack
// BEHAVIOUR
//   Reset: state IDLE, counter 0, all outputs 0; o_rdata=32'h0.
//   FSM IDLE->ACCESS->DONE->IDLE.
//   IDLE: on i_req, latch we/size/signed/addr/wdata and go to ACCESS.
//     With macro on and a misaligned request, go straight to DONE with no bus cycle.
//   ACCESS: o_bus_req=1 with the latched fields, counter counts each cycle.
//     On i_bus_ack: capture load data (loads only) and go to DONE.
//     On counter==TIMEOUT_CYC-1 with no ack: drop the request, set error flag, go to DONE.
//   DONE: o_done=1 (o_bus_err/o_misalign if flagged), o_stall=0, then IDLE.
//     i_req high in the next IDLE cycle starts a new request.
//   o_stall = (state!=DONE) & (i_req | state!=IDLE); combinational, so PC holds in request cycle.
//   Latency with zero-wait bus (ack in first ACCESS cycle): o_done in cycle 2 after i_req seen.
//   Lanes are little-endian.
//     be: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//     wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//   Load: shift rdata right by a[1:0]*8, then sign- or zero-extend from 8 or 16 bits.
//     Word loads pass through unchanged.
//   Error/misaligned loads leave o_rdata unchanged; stores never change o_rdata.
//   Boundaries:
//     - i_bus_ack in IDLE/DONE is ignored.
//     - Ack in the same cycle the timeout expires counts as success.
//     - Async reset mid-ACCESS drops o_bus_req immediately; no o_done is produced.
//     - Address 0xFFFFFFFC word access is legal; no wrap logic is needed.
// CONFIGURATION
//   MEM_MISALIGN_EXC_EN defined: misaligned if half has a[0]=1, or word has a[1:0]!=0.
//     No bus cycle is issued and o_misalign pulses with o_done.
//   Undefined: o_misalign tied 0.
//     Half forces a[0]=0; word forces a[1:0]=0 (for lanes and extraction).
// STRUCTURE
//   Shared include mips32_pkg.vh holds:
//     - size codes MEM_BYTE/MEM_HALF/MEM_WORD
//     - FSM state encodings ST_IDLE/ST_ACCESS/ST_DONE
//   Sub-module mem_lane_align (combinational): size, addr, wdata, rdata, signed -> be, lane wdata, load data.
//   FSM, counter and capture registers live in the top module.
// TESTING
//   1 sw a=0x100 d=0xDEADBEEF, ack after 1 cycle -> be=1111, bus wdata=DEADBEEF, o_done cycle 2, stall cycles 0-1.
//   2 lb a=0x103 signed, rdata=0x80FF0000 -> be=1000, o_rdata=0xFFFFFF80; lbu same -> 0x00000080.
//   3 sh a=0x102 d=0x1234ABCD -> be=1100, wdata=0xABCDABCD; lh a=0x102 rdata=0x7FFF0000 -> 0x00007FFF.
//   4 TIMEOUT_CYC=4, no ack -> o_bus_req high 4 cycles, then o_done+o_bus_err pulse, o_rdata unchanged.
//   5 macro on, lw a=0x101 -> no o_bus_req, o_done+o_misalign next cycle; macro off -> bus addr word 0x40, be=1111.
//   6 reset asserted mid-ACCESS -> o_bus_req/o_stall 0 immediately; late ack ignored; next request completes normally.

Source files
------------

// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data memory access unit: access size codes,
// FSM state encodings and the request fields latched at the start of an access.
package data_mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef struct packed {
        logic        we;
        mem_size_e   size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // The reserved size code behaves as a word access.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = addr_lo[0];
            default:  is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_unit_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// bus, plus little-endian extraction and sign/zero extension of load data.
module mem_lane_align
    import data_mem_access_unit_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        lane    = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            MEM_BYTE: begin
                lane    = i_addr_lo;
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                // Halfwords ignore addr[0]; a misaligned half is forced onto its even lane pair.
                lane    = {i_addr_lo[1], 1'b0};
                o_be    = 4'b0011 << lane;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase

        shifted = i_rdata >> {lane, 3'b000};
        case (i_size)
            MEM_BYTE: o_rdata = {{24{i_signed & shifted[7]}}, shifted[7:0]};
            MEM_HALF: o_rdata = {{16{i_signed & shifted[15]}}, shifted[15:0]};
            default:  o_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-phase access unit: one wait-stated bus transaction per load/store with PC stall.
// Optional MEM_MISALIGN_EXC_EN: misaligned half/word requests complete with o_misalign, no bus cycle.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_bus_err,
    output logic        o_misalign,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             mis_req;
    logic             in_access;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;

`ifdef MEM_MISALIGN_EXC_EN
    assign mis_req = is_misaligned(mem_size_e'(i_size), i_addr[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    mem_lane_align u_lane_align (
        .i_size    (req_q.size),
        .i_addr_lo (req_q.addr[1:0]),
        .i_signed  (req_q.sgn),
        .i_wdata   (req_q.wdata),
        .i_rdata   (i_bus_rdata),
        .o_be      (lane_be),
        .o_wdata   (lane_wdata),
        .o_rdata   (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    req_d   = '{we: i_we, size: mem_size_e'(i_size), sgn: i_signed,
                                addr: i_addr, wdata: i_wdata};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    mis_d   = mis_req;
                    state_d = mis_req ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (i_bus_ack) begin
                    if (!req_q.we) rdata_d = lane_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the capture registers are
    // reset as well because o_rdata must read zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_access   = (state_q == ST_ACCESS);
    assign o_bus_req   = in_access;
    assign o_bus_we    = in_access & req_q.we;
    assign o_bus_addr  = in_access ? req_q.addr[31:2] : 30'h0;
    assign o_bus_be    = in_access ? lane_be : 4'h0;
    assign o_bus_wdata = in_access ? lane_wdata : 32'h0;

    assign o_done      = (state_q == ST_DONE);
    assign o_bus_err   = o_done & err_q;
    assign o_misalign  = o_done & mis_q;
    assign o_rdata     = rdata_q;

    // Combinational on i_req so the PC already holds in the request cycle; forced low in reset.
    assign o_stall = i_rst_n & (state_q != ST_DONE) & (i_req | (state_q != ST_IDLE));

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: per-cycle timeline model plus directed literals
// and randomized load/store traffic with random wait states, timeouts and stray acks.
module tb_data_mem_access_unit;

    localparam int TB_T = 4;
`ifdef MEM_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_done;
    logic        o_bus_err;
    logic        o_misalign;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [29:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    data_mem_access_unit #(.TIMEOUT_CYC(TB_T)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_bus_err   (o_bus_err),
        .o_misalign  (o_misalign),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected per-cycle outputs, written by the driver, compared on the falling edge.
    logic        exp_valid = 1'b0;
    logic        exp_bus_req, exp_bus_we, exp_stall, exp_done, exp_err, exp_mis;
    logic [29:0] exp_bus_addr;
    logic [3:0]  exp_bus_be;
    logic [31:0] exp_bus_wdata;
    logic [31:0] model_rdata = 32'h0;

    // Observations of the DUT for the directed literal checks.
    int          req_cycles;
    int          done_cyc;
    int          start_cyc;
    logic        err_seen, mis_seen;
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] size, input logic [1:0] a);
        return MIS_EN && ((size == 2'b01 && a[0]) || (size[1] && a != 2'b00));
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'b00) return 4'b0001 << a;
        if (size == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'b00) return {4{d[7:0]}};
        if (size == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] a, input logic [31:0] rd);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        off = 8 * int'(a);
        b   = rd[off +: 8];
        h   = a[1] ? rd[31:16] : rd[15:0];
        if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
        if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        return rd;
    endfunction

    task automatic set_exp_idle();
        exp_bus_req   = 1'b0;
        exp_bus_we    = 1'b0;
        exp_bus_addr  = 30'h0;
        exp_bus_be    = 4'h0;
        exp_bus_wdata = 32'h0;
        exp_stall     = 1'b0;
        exp_done      = 1'b0;
        exp_err       = 1'b0;
        exp_mis       = 1'b0;
    endtask

    always @(posedge i_clk) cyc++;

    // Single compare process plus observation capture.
    always @(negedge i_clk) begin
        if (exp_valid) begin
            check("bus_req",   o_bus_req,   exp_bus_req);
            check("bus_we",    o_bus_we,    exp_bus_we);
            check("bus_addr",  o_bus_addr,  exp_bus_addr);
            check("bus_be",    o_bus_be,    exp_bus_be);
            check("bus_wdata", o_bus_wdata, exp_bus_wdata);
            check("stall",     o_stall,     exp_stall);
            check("done",      o_done,      exp_done);
            check("bus_err",   o_bus_err,   exp_err);
            check("misalign",  o_misalign,  exp_mis);
            check("rdata",     o_rdata,     model_rdata);
        end
        if (o_bus_req) begin
            req_cycles++;
            cap_addr  = o_bus_addr;
            cap_be    = o_bus_be;
            cap_wdata = o_bus_wdata;
        end
        if (o_done) begin
            done_cyc = cyc;
            err_seen = o_bus_err;
            mis_seen = o_misalign;
        end
    end

    // One request from the IDLE cycle that presents it through o_done. ack_at is the ACCESS
    // cycle index (0 = first) carrying the ack; ack_at >= TB_T means the bus never answers.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata, input logic gap);
        logic mis;
        logic acked;
        mis        = model_mis(size, addr[1:0]);
        acked      = 1'b0;
        req_cycles = 0;
        err_seen   = 1'b0;
        mis_seen   = 1'b0;
        done_cyc   = -1;
        start_cyc  = cyc;
        i_req = 1'b1; i_we = we; i_size = size; i_signed = sgn; i_addr = addr; i_wdata = wdata;
        i_bus_ack = 1'b0; i_bus_rdata = $urandom;
        set_exp_idle();
        exp_stall = 1'b1;
        @(posedge i_clk); #1;
        if (!mis) begin
            for (int c = 0; c < TB_T; c++) begin
                i_bus_ack   = (c == ack_at);
                i_bus_rdata = (c == ack_at) ? rdata : $urandom;
                set_exp_idle();
                exp_bus_req   = 1'b1;
                exp_bus_we    = we;
                exp_bus_addr  = addr[31:2];
                exp_bus_be    = model_be(size, addr[1:0]);
                exp_bus_wdata = model_wdata(size, wdata);
                exp_stall     = 1'b1;
                @(posedge i_clk); #1;
                if (c == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        if (acked && !we) model_rdata = model_load(size, sgn, addr[1:0], rdata);
        set_exp_idle();
        exp_done = 1'b1;
        exp_err  = !mis && !acked;
        exp_mis  = mis;
        i_bus_ack   = 1'($urandom_range(0, 1));
        i_bus_rdata = $urandom;
        @(posedge i_clk); #1;
        i_bus_ack = 1'b0;
        set_exp_idle();
        if (gap) begin
            i_req     = 1'b0;
            i_bus_ack = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
            i_bus_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_signed = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
        set_exp_idle();
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_bus_req", o_bus_req, 1'b0);
        check("reset_stall",   o_stall,   1'b0);
        check("reset_done",    o_done,    1'b0);
        check("reset_rdata",   o_rdata,   32'h0);
        check("reset_be",      o_bus_be,  4'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        exp_valid = 1'b1;

        // sw with zero-wait bus
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 1'b1);
        check("sw_be",      cap_be,    4'b1111);
        check("sw_wdata",   cap_wdata, 32'hDEAD_BEEF);
        check("sw_latency", done_cyc - start_cyc, 2);
        check("sw_rdata_unchanged", o_rdata, 32'h0);

        // lb / lbu on the top byte lane
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000, 1'b1);
        check("lb_be",    cap_be,  4'b1000);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h80FF_0000, 1'b0);
        check("lbu_rdata", o_rdata, 32'h0000_0080);

        // sh / lh on the upper half
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 2, 32'h0, 1'b1);
        check("sh_be",    cap_be,    4'b1100);
        check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 0, 32'h7FFF_0000, 1'b1);
        check("lh_rdata", o_rdata, 32'h0000_7FFF);

        // timeout: no ack at all
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 99, 32'h0, 1'b1);
        check("to_req_cycles", req_cycles, TB_T);
        check("to_bus_err",    err_seen,   1'b1);
        check("to_rdata_kept", o_rdata,    32'h0000_7FFF);

        // ack in the very cycle the timeout expires is a success
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0, TB_T - 1, 32'h1122_3344, 1'b1);
        check("late_ack_req_cycles", req_cycles, TB_T);
        check("late_ack_no_err",     err_seen,   1'b0);
        check("late_ack_rdata",      o_rdata,    32'h1122_3344);

        // misaligned word load
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 0, 32'h5566_7788, 1'b1);
        if (MIS_EN) begin
            check("mis_no_bus",  req_cycles, 0);
            check("mis_flag",    mis_seen,   1'b1);
            check("mis_latency", done_cyc - start_cyc, 1);
        end else begin
            check("lw_forced_addr", cap_addr, 30'h40);
            check("lw_forced_be",   cap_be,   4'b1111);
        end

        // top-of-memory word
        run_txn(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
        check("top_addr",  cap_addr, 30'h3FFF_FFFF);
        check("top_rdata", o_rdata,  32'hCAFE_F00D);

        // async reset in the middle of ACCESS
        i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_signed = 1'b0;
        i_addr = 32'h0000_0200; i_wdata = 32'h0000_0055;
        set_exp_idle();
        exp_stall = 1'b1;
        @(posedge i_clk); #1;
        exp_bus_req = 1'b1; exp_bus_we = 1'b1; exp_bus_addr = 30'h80;
        exp_bus_be = 4'hF; exp_bus_wdata = 32'h0000_0055;
        @(posedge i_clk); #2;
        exp_valid = 1'b0;
        i_rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check("rst_mid_bus_req", o_bus_req, 1'b0);
        check("rst_mid_stall",   o_stall,   1'b0);
        check("rst_mid_done",    o_done,    1'b0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("rst_after_done",    o_done,    1'b0);
            check("rst_after_bus_req", o_bus_req, 1'b0);
            check("rst_after_rdata",   o_rdata,   32'h0);
        end
        i_bus_ack = 1'b0;
        model_rdata = 32'h0;
        set_exp_idle();
        @(posedge i_clk); #1;
        exp_valid = 1'b1;
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h8001_2345, 1'b1);
        check("post_rst_lhu", o_rdata, 32'h0000_2345);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, int'($urandom_range(0, TB_T + 1)), $urandom,
                    1'($urandom_range(0, 1)));
        end

        exp_valid = 1'b0;
        i_req = 1'b0;
        @(posedge i_clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
